// File: rtl/mul_hilo_unit_if.sv
// Operand/control bundle between the pipeline and the iterative multiplier with its HI/LO pair.
interface mul_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [2:0]       MulOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi_out;
  logic [WIDTH-1:0] Lo_out;

  modport master (
    output Start, MulOp, A, B, Flush,
    input  Busy, Done, Hi_out, Lo_out
  );

  modport slave (
    input  Start, MulOp, A, B, Flush,
    output Busy, Done, Hi_out, Lo_out
  );
endinterface

// File: rtl/mul_hilo_unit.sv
// Shift-add multiplier (one product bit per cycle) owning the architectural HI/LO registers.
// Handles mult/multu/madd/msub in WIDTH+1 cycles and mthi/mtlo in one edge.
module mul_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          Clk,
  input logic          Rst,
  mul_hilo_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMadd  = 3'b010;
  localparam logic [2:0] OpMsub  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StMul, StFin} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod, hilo;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    done_d  = 1'b0;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1) cleanly.
    abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    prod  = neg_q ? -acc_q : acc_q;
    hilo  = {hi_q, lo_q};

    case (state_q)
      StIdle: begin
        if (bus.Start && !bus.Flush) begin
          case (bus.MulOp)
            OpMthi: hi_d = bus.A;
            OpMtlo: lo_d = bus.A;
            OpMult, OpMadd, OpMsub: begin
              state_d = StMul;
              cnt_d   = '0;
              op_d    = bus.MulOp[1:0];
              mcand_d = abs_a;
              acc_d   = {{WIDTH{1'b0}}, abs_b};
              neg_d   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            end
            OpMultu: begin
              state_d = StMul;
              cnt_d   = '0;
              op_d    = bus.MulOp[1:0];
              mcand_d = bus.A;
              acc_d   = {{WIDTH{1'b0}}, bus.B};
              neg_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        if (bus.Flush) begin
          state_d = StIdle;
        end else begin
          // Multiplier lives in the low half and drains out as the partial product shifts in.
          acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        if (!bus.Flush) begin
          done_d = 1'b1;
          case (op_q)
            2'b10:   {hi_d, lo_d} = hilo + prod;
            2'b11:   {hi_d, lo_d} = hilo - prod;
            default: {hi_d, lo_d} = prod;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Hi_out = hi_q;
  assign bus.Lo_out = lo_q;
endmodule
